// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetch into a DEPTH-entry {pc, instr} queue; redirect flushes the queue and restarts fetch.
// Latency: request -> data next cycle -> instr_valid the cycle after (same cycle as the data with FETCH_BYPASS_EN).
// Backpressure: a request is issued only while queued + in-flight < DEPTH; the head is held while !instr_ready.
module instr_fetch_queue #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       DEPTH         = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     instr_valid,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    input  logic                     instr_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDRESS_WIDTH-1:0] fetch_pc;
    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic                     inflight;
    logic [CNT_W-1:0]         count;
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         wr_ptr;
    logic [ADDRESS_WIDTH-1:0] fifo_pc    [DEPTH];
    logic [DATA_WIDTH-1:0]    fifo_instr [DEPTH];

    logic [CNT_W:0]           occupancy;
    logic                     credit;
    logic                     resp;
    logic                     push;
    logic                     pop_fifo;
    logic                     unused_pc_lsbs;

    assign unused_pc_lsbs = ^redirect_pc[1:0];

    // A pop in the same cycle does not return a credit; that keeps the check off the decode path.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign credit    = occupancy < (CNT_W + 1)'(DEPTH);
    assign imem_req  = rst && !redirect && credit;
    assign imem_addr = fetch_pc;
    assign resp      = inflight && !redirect;

`ifdef FETCH_BYPASS_EN
    logic bypass;

    assign bypass = resp && (count == '0);

    always_comb begin
        instr_valid = (count != '0) || bypass;
        instr       = bypass ? imem_rdata : fifo_instr[rd_ptr];
        instr_pc    = bypass ? pc_q       : fifo_pc[rd_ptr];
        pop_fifo    = instr_ready && (count != '0);
        push        = resp && !(bypass && instr_ready);
    end
`else
    always_comb begin
        instr_valid = (count != '0);
        instr       = fifo_instr[rd_ptr];
        instr_pc    = fifo_pc[rd_ptr];
        pop_fifo    = instr_valid && instr_ready;
        push        = resp;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            pc_q     <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (redirect) begin
                fetch_pc <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
            end else if (imem_req) begin
                fetch_pc <= fetch_pc + ADDRESS_WIDTH'(4);
                pc_q     <= fetch_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
        end else if (redirect) begin
            // A same-cycle pop is already owned by decode; everything else is dropped.
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]    <= pc_q;
                fifo_instr[wr_ptr] <= imem_rdata;
                wr_ptr             <= wr_ptr + PTR_W'(1);
            end
            if (pop_fifo) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop_fifo})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue against a queue-based reference of the fetch rules.
module tb_instr_fetch_queue;
    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'hFFFF_FFF8;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata = '0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          instr_valid;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready = 1'b0;

    instr_fetch_queue #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .RESET_PC     (RPC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // Synchronous memory; cycles without a request return junk that must never be queued.
    always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : $urandom;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fpc = RPC;
    logic [31:0] m_pcq = '0;
    bit          m_infl = 1'b0;
    bit          e_req, e_vld, e_byp;
    ent_t        e_head;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          first_vld_cyc = -1;
    bit          o_vld, o_req;
    logic [31:0] o_pc, o_addr;
    int          o_cyc;
    logic [31:0] delivered[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_outputs(input bit redir);
        e_req = !redir && ((mq.size() + int'(m_infl)) < DEPTH);
`ifdef FETCH_BYPASS_EN
        e_byp = (mq.size() == 0) && m_infl && !redir;
`else
        e_byp = 1'b0;
`endif
        e_vld  = (mq.size() != 0) || e_byp;
        e_head = (mq.size() != 0) ? mq[0] : {m_pcq, mem_word(m_pcq)};
    endtask

    task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc);
        @(negedge clk);
        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        #1;
        model_outputs(redir);
        check_eq("imem_req", imem_req, e_req);
        check_eq("imem_addr", imem_addr, m_fpc);
        check_eq("instr_valid", instr_valid, e_vld);
        if (e_vld) begin
            check_eq("instr_pc", instr_pc, e_head.pc);
            check_eq("instr", instr, e_head.ins);
        end
        o_vld  = instr_valid;
        o_pc   = instr_pc;
        o_req  = imem_req;
        o_addr = imem_addr;
        o_cyc  = cyc;
        if (instr_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (instr_valid && rdy) delivered.push_back(instr_pc);
        @(posedge clk);
        if (e_vld && rdy && mq.size() != 0) void'(mq.pop_front());
        if (redir) begin
            mq.delete();
            m_fpc  = {rpc[31:2], 2'b00};
            m_infl = 1'b0;
        end else begin
            if (m_infl && !(e_byp && rdy)) mq.push_back({m_pcq, mem_word(m_pcq)});
            if (e_req) begin
                m_pcq = m_fpc;
                m_fpc = m_fpc + 32'd4;
            end
            m_infl = e_req;
        end
        cyc++;
    endtask

    // Asserts reset between clock edges, checks the immediate effect, releases just after an edge.
    task automatic do_reset();
        @(negedge clk);
        redirect = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_eq("rst_instr_valid", instr_valid, 1'b0);
        check_eq("rst_imem_req", imem_req, 1'b0);
        check_eq("rst_imem_addr", imem_addr, RPC);
        check_eq("rst_instr_pc", instr_pc, 32'h0);
        check_eq("rst_instr", instr, 32'h0);
        mq.delete();
        m_fpc  = RPC;
        m_pcq  = '0;
        m_infl = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 1;
        first_vld_cyc = -1;
        delivered.delete();
    endtask

    initial begin
        bit reached;
        int rcyc;

        // Sequential stream from a reset PC that wraps.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
        check_eq("first_valid_cycle", 64'(first_vld_cyc), 64'(LAT));
        check_eq("wrap_pc0", delivered[0], 32'hFFFF_FFF8);
        check_eq("wrap_pc1", delivered[1], 32'hFFFF_FFFC);
        check_eq("wrap_pc2", delivered[2], 32'h0000_0000);
        check_eq("wrap_pc3", delivered[3], 32'h0000_0004);

        // Redirect mid-stream to an unaligned target.
        rcyc = cyc;
        step(1'b1, 1'b1, 32'h0000_0103);
        reached = 1'b0;
        for (int i = 0; i < 10 && !reached; i++) begin
            step(1'b1, 1'b0, '0);
            if (o_vld) reached = 1'b1;
        end
        check_eq("redir_seen", reached, 1'b1);
        check_eq("redir_latency", 64'(o_cyc - rcyc), 64'(LAT));
        check_eq("redir_pc", o_pc, 32'h0000_0100);

        // Stall long enough to fill, then drain in order.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
        check_eq("full_no_req", imem_req, 1'b0);
        check_eq("full_valid", instr_valid, 1'b1);
        delivered.delete();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);
        for (int i = 1; i < delivered.size(); i++)
            check_eq("drain_order", delivered[i], delivered[i-1] + 32'd4);

        // Redirect while full with a simultaneous pop.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
        delivered.delete();
        step(1'b1, 1'b1, 32'h0000_2002);
        check_eq("full_redir_pop_count", 64'(delivered.size()), 64'd1);
        step(1'b1, 1'b0, '0);
        check_eq("full_redir_req", o_req, 1'b1);
        check_eq("full_redir_addr", o_addr, 32'h0000_2000);
        check_eq("full_redir_empty", o_vld, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);

        // Async reset with three entries queued and one in flight.
        do_reset();
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            step(1'b0, 1'b0, '0);
            if (mq.size() == 3 && m_infl) reached = 1'b1;
        end
        check_eq("fill3_reached", reached, 1'b1);
        do_reset();
        step(1'b1, 1'b0, '0);
        check_eq("restart_req", o_req, 1'b1);
        check_eq("restart_addr", o_addr, RPC);

        // Random traffic: ready, redirects (including back-to-back), occasional reset.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
